pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the CE and sync-clear

---
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline (load-use, branch squash, MDU hold, dmem wait).
// Latency: enables and flushes are combinational from the current state and inputs; the MDU hold lasts MDU_LAT cycles.
// Backpressure: a dmem wait freezes every pipeline register and holds all sequencer state.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_br_taken,
    input  logic            ex_mdu_start,
    input  logic            mem_req,
    input  logic            dmem_ready,
    output logic            pc_ce,
    output logic            ifid_ce,
    output logic            idex_ce,
    output logic            exmem_ce,
    output logic            memwb_ce,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            mdu_busy
);

    localparam int CW = $clog2(MDU_LAT);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          done_q, done_nx;

    logic freeze;
    logic mdu_trig;
    logic load_use;

    // Hazard detection shared by the next-state and output logic.
    always_comb begin
        freeze   = mem_req & ~dmem_ready;
        // done_q lets the finished MDU op leave EX without being restarted by its own held start level.
        mdu_trig = (state == ST_RUN) & ex_mdu_start & ~done_q & ~freeze;
        // Register 0 is hardwired, so a load targeting it can never create a dependency.
        load_use = ex_mem_read & (ex_rd != '0) &
                   ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    end

    // State register: sequencer mode, MDU countdown and the post-MDU retrigger guard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
        end
    end

    // Next-state: a frozen cycle changes nothing; otherwise advance the MDU countdown.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = done_q;
        if (!freeze) begin
            case (state)
                ST_RUN: begin
                    // The guard only needs to cover the single cycle in which the op moves out of EX.
                    done_nx = 1'b0;
                    if (mdu_trig) begin
                        // The trigger cycle itself is the first of the MDU_LAT held cycles.
                        state_nx = ST_MDU;
                        cnt_nx   = CW'(MDU_LAT - 1);
                    end
                end
                ST_MDU: begin
                    if (cnt == CW'(1)) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                default: begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                    done_nx  = 1'b0;
                end
            endcase
        end
    end

    // Outputs: priority freeze > MDU > branch > load-use > normal; all zero while reset is asserted.
    always_comb begin
        pc_ce       = 1'b0;
        ifid_ce     = 1'b0;
        idex_ce     = 1'b0;
        exmem_ce    = 1'b0;
        memwb_ce    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mdu_busy    = 1'b0;
        if (rst) begin
            mdu_busy = (state == ST_MDU);
            if (freeze) begin
                // Every register holds; nothing is cleared.
            end else if (mdu_trig || state == ST_MDU) begin
                // Hold the front end and the MDU op in EX, and feed bubbles into MEM.
                exmem_ce    = 1'b1;
                exmem_flush = 1'b1;
                memwb_ce    = 1'b1;
            end else if (ex_br_taken) begin
                // Squash the two wrong-path instructions in IF/ID and ID/EX.
                pc_ce      = 1'b1;
                ifid_ce    = 1'b1;
                idex_ce    = 1'b1;
                exmem_ce   = 1'b1;
                memwb_ce   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                // Hold the consumer in ID for one cycle and insert a bubble behind the load.
                idex_ce    = 1'b1;
                idex_flush = 1'b1;
                exmem_ce   = 1'b1;
                memwb_ce   = 1'b1;
            end else begin
                pc_ce    = 1'b1;
                ifid_ce  = 1'b1;
                idex_ce  = 1'b1;
                exmem_ce = 1'b1;
                memwb_ce = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: directed checks of the hazard sequencer with a short MDU latency.
// Latency: inputs are driven after the falling edge and outputs are sampled 1 ns later.
// Backpressure: dmem waits are exercised both in RUN and in the middle of an MDU hold.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_mem_read, ex_br_taken, ex_mdu_start;
    logic       mem_req, dmem_ready;
    logic       pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce;
    logic       ifid_flush, idex_flush, exmem_flush, mdu_busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Output vector: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, mdu_busy}
    localparam logic [8:0] P_ZERO   = 9'b00000_000_0;
    localparam logic [8:0] P_NORMAL = 9'b11111_000_0;
    localparam logic [8:0] P_LDUSE  = 9'b00111_010_0;
    localparam logic [8:0] P_BRANCH = 9'b11111_110_0;
    localparam logic [8:0] P_MDU_T  = 9'b00011_001_0;
    localparam logic [8:0] P_MDU_B  = 9'b00011_001_1;
    localparam logic [8:0] P_FRZ_B  = 9'b00000_000_1;

    pipe_hazard_ctrl #(.MDU_LAT(4), .RA_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_br_taken  (ex_br_taken),
        .ex_mdu_start (ex_mdu_start),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .pc_ce        (pc_ce),
        .ifid_ce      (ifid_ce),
        .idex_ce      (idex_ce),
        .exmem_ce     (exmem_ce),
        .memwb_ce     (memwb_ce),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .mdu_busy     (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the falling edge so new inputs settle well away from the active edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_mem_read = 1'b0; ex_br_taken = 1'b0; ex_mdu_start = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic check(input string tag, input logic [8:0] expected);
        logic [8:0] observed;
        #1;
        observed = {pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce,
                    ifid_flush, idex_flush, exmem_flush, mdu_busy};
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;

        // Reset: outputs all zero even with an active hazard present.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        next_cycle();
        check("reset_outputs", P_ZERO);
        clear_inputs();
        next_cycle();
        rst = 1'b1;
        check("after_reset_normal", P_NORMAL);

        // Load-use on rs: one bubble, then normal once the load has moved on.
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        id_rt = 5'd1; id_use_rt = 1'b1;
        check("loaduse_rs", P_LDUSE);
        next_cycle();
        ex_mem_read = 1'b0; ex_rd = 5'd6;
        check("loaduse_next_normal", P_NORMAL);

        // Load-use on rt only.
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd2; id_use_rs = 1'b1;
        id_rt = 5'd7; id_use_rt = 1'b1;
        check("loaduse_rt", P_LDUSE);

        // Load into r0 never stalls.
        next_cycle();
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        id_rt = 5'd0; id_use_rt = 1'b1;
        check("loaduse_r0_none", P_NORMAL);

        // Matching register that is not actually read does not stall.
        next_cycle();
        ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0; id_rt = 5'd5; id_use_rt = 1'b0;
        check("loaduse_unused_none", P_NORMAL);

        // Branch overrides a coincident load-use.
        next_cycle();
        id_use_rs = 1'b1; ex_br_taken = 1'b1;
        check("branch_over_loaduse", P_BRANCH);

        // Dmem wait in RUN freezes everything; a ready access does not.
        next_cycle();
        mem_req = 1'b1; dmem_ready = 1'b0;
        check("freeze_run", P_ZERO);
        next_cycle();
        clear_inputs();
        mem_req = 1'b1; dmem_ready = 1'b1;
        check("mem_ready_normal", P_NORMAL);

        // MDU hold of exactly 4 cycles, then the op leaves without retriggering.
        next_cycle();
        clear_inputs();
        ex_mdu_start = 1'b1;
        check("mdu1_trigger", P_MDU_T);
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            check($sformatf("mdu1_cycle%0d", i), P_MDU_B);
        end
        next_cycle();
        check("mdu1_release", P_NORMAL);
        next_cycle();
        ex_mdu_start = 1'b0;
        check("mdu1_after", P_NORMAL);

        // MDU with a taken branch held alongside and a 2-cycle dmem wait inside the hold.
        next_cycle();
        ex_mdu_start = 1'b1; ex_br_taken = 1'b1;
        check("mdu2_trigger_over_branch", P_MDU_T);
        next_cycle();
        check("mdu2_cycle2", P_MDU_B);
        next_cycle();
        mem_req = 1'b1; dmem_ready = 1'b0;
        check("mdu2_frozen_a", P_FRZ_B);
        next_cycle();
        check("mdu2_frozen_b", P_FRZ_B);
        next_cycle();
        mem_req = 1'b0; dmem_ready = 1'b1;
        check("mdu2_cycle3", P_MDU_B);
        next_cycle();
        check("mdu2_cycle4", P_MDU_B);
        // Release cycle frozen: the retrigger guard must survive the wait.
        next_cycle();
        mem_req = 1'b1; dmem_ready = 1'b0;
        check("mdu2_release_frozen", P_ZERO);
        next_cycle();
        mem_req = 1'b0; dmem_ready = 1'b1;
        check("mdu2_release_branch", P_BRANCH);
        next_cycle();
        clear_inputs();
        check("mdu2_after", P_NORMAL);

        // Reset asserted mid-MDU with cnt at 2 aborts the hold.
        next_cycle();
        ex_mdu_start = 1'b1;
        check("mdu3_trigger", P_MDU_T);
        next_cycle();
        check("mdu3_cycle2", P_MDU_B);
        next_cycle();
        rst = 1'b0;
        check("mdu3_reset_zero", P_ZERO);
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        check("mdu3_after_reset", P_NORMAL);
        next_cycle();
        check("mdu3_after_reset2", P_NORMAL);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
